// File: rtl/string_match_master_if.sv
// Memory-side bus of the string matcher: word-aligned byte address,
// write data, read/write strobes and same-cycle combinational read data.
interface string_match_master_if;
   logic [31:0] Address;
   logic [31:0] Write_data;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Read_data;

   modport master (
      output Address, Write_data, MemRead, MemWrite,
      input  Read_data
   );

   modport slave (
      input  Address, Write_data, MemRead, MemWrite,
      output Read_data
   );
endinterface

// File: rtl/string_match_master.sv
// Naive substring counter: walks every alignment i of the pattern over the
// text, reading one text byte and one pattern byte per compared character,
// then writes the match count to the LED register and pulses done.
module string_match_master #(
   parameter logic [31:0] STR_BASE = 32'h00000000,
   parameter logic [31:0] PAT_BASE = 32'h00000400,
   parameter logic [31:0] LED_ADDR = 32'h4000000C
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [8:0]                    str_len,
   input  logic [8:0]                    pat_len,
   string_match_master_if.master         mem,
   output logic                          busy,
   output logic                          done,
   output logic [15:0]                   count
);

   typedef enum logic [2:0] {IDLE, RD_S, RD_P, WR_LED, DONE} state_t;

   state_t      state, state_nxt;
   logic [8:0]  i, j;
   logic [8:0]  slen, plen;
   logic [7:0]  s_byte;

   logic [9:0]  idx;
   logic [8:0]  limit;
   logic [8:0]  i_new;
   logic        is_match;
   logic        last;
   logic        i_adv;
   logic        degenerate;
   logic        unused_rd;

   assign unused_rd = ^mem.Read_data[31:8];

   // Match bookkeeping shared by the next-state logic and the datapath.
   always_comb begin
      idx        = {1'b0, i} + {1'b0, j};
      limit      = (plen <= slen) ? (slen - plen) : '0;
      is_match   = (mem.Read_data[7:0] == s_byte);
      last       = (j == plen - 9'd1);
      i_adv      = !is_match || last;
      i_new      = i_adv ? (i + 9'd1) : i;
      degenerate = (pat_len == '0) || (pat_len > str_len);
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and bus outputs; strobes and bus fields are zero by default.
   always_comb begin
      state_nxt      = state;
      mem.MemRead    = 1'b0;
      mem.MemWrite   = 1'b0;
      mem.Address    = '0;
      mem.Write_data = '0;
      busy           = (state != IDLE);
      done           = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = degenerate ? WR_LED : RD_S;
         end
         RD_S: begin
            mem.MemRead = 1'b1;
            mem.Address = STR_BASE + {20'b0, idx, 2'b00};
            state_nxt   = RD_P;
         end
         RD_P: begin
            mem.MemRead = 1'b1;
            mem.Address = PAT_BASE + {21'b0, j, 2'b00};
            state_nxt   = (i_new > limit) ? WR_LED : RD_S;
         end
         WR_LED: begin
            mem.MemWrite   = 1'b1;
            mem.Address    = LED_ADDR;
            mem.Write_data = {16'b0, count};
            state_nxt      = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: length latch, text byte capture, indices and saturating count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slen   <= '0;
         plen   <= '0;
         s_byte <= '0;
         i      <= '0;
         j      <= '0;
         count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  slen  <= str_len;
                  plen  <= pat_len;
                  i     <= '0;
                  j     <= '0;
                  count <= '0;
               end
            end
            RD_S: s_byte <= mem.Read_data[7:0];
            RD_P: begin
               if (i_adv) begin
                  j <= '0;
                  i <= i_new;
               end else begin
                  j <= j + 9'd1;
               end
               if (is_match && last && (count != '1)) count <= count + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
